// File: rtl/fb_sram_arbiter_pkg.sv
// Shared types and constants for the framebuffer SRAM arbiter.
// Used by fb_sram_arbiter (top) and fb_sram_io (pin registers).

package fb_sram_arbiter_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } arb_state_t;

    // Default bus widths of the board SRAM.
    localparam int SRAM_AW_DEF = 18;
    localparam int SRAM_DW_DEF = 16;

    // Active-low SRAM control strobes; be_n is {UB_N, LB_N}.
    typedef struct packed {
        logic       ce_n;
        logic       oe_n;
        logic       we_n;
        logic [1:0] be_n;
    } sram_strobe_t;

    // Everything deasserted: used in reset and whenever the FSM is idle.
    localparam sram_strobe_t SRAM_STROBE_IDLE = '{
        ce_n: 1'b1,
        oe_n: 1'b1,
        we_n: 1'b1,
        be_n: 2'b11
    };

    // Read access: chip and output enabled, both bytes selected.
    localparam sram_strobe_t SRAM_STROBE_READ = '{
        ce_n: 1'b0,
        oe_n: 1'b0,
        we_n: 1'b1,
        be_n: 2'b00
    };

    // Write access strobes; we_n is released in the hold cycle so the
    // SRAM latches data on the rising edge of we_n while addr/data are stable.
    function automatic sram_strobe_t write_strobe(input logic       hold,
                                                  input logic [1:0] be_n);
        sram_strobe_t s;
        s.ce_n = 1'b0;
        s.oe_n = 1'b1;
        s.we_n = hold;
        s.be_n = be_n;
        return s;
    endfunction

endpackage

// File: rtl/fb_sram_io.sv
// SRAM pin registers: address, control strobes, registered tri-state
// driver for the data bus and the read-data capture register.
// Every pin value here is loaded from the arbiter's next-state decode, so
// the pins change on the same edge as the FSM state.

module fb_sram_io
    import fb_sram_arbiter_pkg::*;
#(
    parameter int SRAM_AW = SRAM_AW_DEF,
    parameter int SRAM_DW = SRAM_DW_DEF
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               addr_load,
    input  logic [SRAM_AW-1:0] addr_next,
    input  logic               data_load,
    input  logic [SRAM_DW-1:0] data_next,
    input  logic               ce_n_next,
    input  logic               oe_n_next,
    input  logic               we_n_next,
    input  logic [1:0]         be_n_next,
    input  logic               dq_oe_next,
    input  logic               capture,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [1:0]         sram_be_n,
    output logic [SRAM_DW-1:0] rd_data
);

    logic               dq_oe;
    logic [SRAM_DW-1:0] dq_out;

    // Address register: only updated on a grant, holds its value while idle.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sram_addr <= '0;
        end else if (addr_load) begin
            sram_addr <= addr_next;
        end
    end

    // Control strobes, reloaded every cycle from the FSM decode.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n} <= SRAM_STROBE_IDLE;
        end else begin
            sram_ce_n <= ce_n_next;
            sram_oe_n <= oe_n_next;
            sram_we_n <= we_n_next;
            sram_be_n <= be_n_next;
        end
    end

    // Write data and its output enable; the enable is registered like the
    // strobes so the bus turns around on the same edge as oe_n.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            dq_oe  <= 1'b0;
            dq_out <= '0;
        end else begin
            dq_oe <= dq_oe_next;
            if (data_load) begin
                dq_out <= data_next;
            end
        end
    end

    assign sram_dq = dq_oe ? dq_out : {SRAM_DW{1'bz}};

    // Read data capture at the end of the last read cycle.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rd_data <= '0;
        end else if (capture) begin
            rd_data <= sram_dq;
        end
    end

endmodule

// File: rtl/fb_sram_arbiter.sv
// Framebuffer SRAM arbiter: shares one asynchronous 16-bit SRAM between
// the pixel-fetch read port and the drawing/CPU write port.
// Optional feature macro: FB_SRAM_ARB_STARVE_EN (write anti-starvation).
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | strobes inactive, bus released; grants one request (read first)
//   READ  | ce_n/oe_n low for RD_CYCLE cycles, data captured in last one
//   WRITE | we_n low for WR_CYCLE-1 cycles, then one hold cycle

module fb_sram_arbiter
    import fb_sram_arbiter_pkg::*;
#(
    parameter int SRAM_AW    = SRAM_AW_DEF,
    parameter int SRAM_DW    = SRAM_DW_DEF,
    parameter int RD_CYCLE   = 2,
    parameter int WR_CYCLE   = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               rd_read,
    input  logic [SRAM_AW-1:0] rd_address,
    output logic               rd_waitrequest,
    output logic [SRAM_DW-1:0] rd_readdata,
    output logic               rd_readdatavalid,
    input  logic               wr_write,
    input  logic [SRAM_AW-1:0] wr_address,
    input  logic [SRAM_DW-1:0] wr_writedata,
    input  logic [1:0]         wr_byteenable,
    output logic               wr_waitrequest,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [1:0]         sram_be_n
);

    // Access-length down-counter holds the remaining cycles minus one.
    localparam int CNT_MAX = (RD_CYCLE > WR_CYCLE) ? RD_CYCLE : WR_CYCLE;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    if (RD_CYCLE < 1 || WR_CYCLE < 2 || STARVE_MAX < 1) begin : g_param_check
        $error("fb_sram_arbiter: RD_CYCLE>=1, WR_CYCLE>=2, STARVE_MAX>=1 required");
    end

    arb_state_t         state;
    arb_state_t         state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               rd_grant;
    logic               wr_grant;
    logic               force_wr;
    sram_strobe_t       strobe_next;
    logic               dq_oe_next;
    logic               addr_load;
    logic [SRAM_AW-1:0] addr_next;
    logic               data_load;
    logic               capture;
    logic               rd_valid_q;

`ifdef FB_SRAM_ARB_STARVE_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    logic [STARVE_W-1:0] starve_cnt;

    // Saturating count of reads granted while a write waits.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || wr_grant || !wr_write) begin
            starve_cnt <= '0;
        end else if (rd_grant && (starve_cnt != STARVE_W'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

    assign force_wr = wr_write && (starve_cnt == STARVE_W'(STARVE_MAX));
`else
    assign force_wr = 1'b0;
`endif

    // Grant decode: only in IDLE and out of reset; read wins unless forced.
    always_comb begin
        rd_grant = sys_rst_n && (state == IDLE) && rd_read && !force_wr;
        wr_grant = sys_rst_n && (state == IDLE) && wr_write && (!rd_read || force_wr);
    end

    assign rd_waitrequest = !rd_grant;
    assign wr_waitrequest = !wr_grant;

    // State and access counter registers.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state plus the pin values the SRAM sees in the next cycle.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        strobe_next = SRAM_STROBE_IDLE;
        dq_oe_next  = 1'b0;
        addr_load   = 1'b0;
        addr_next   = rd_address;
        data_load   = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (rd_grant) begin
                    state_next  = READ;
                    cnt_next    = CNT_W'(RD_CYCLE - 1);
                    strobe_next = SRAM_STROBE_READ;
                    addr_load   = 1'b1;
                    addr_next   = rd_address;
                end else if (wr_grant) begin
                    state_next  = WRITE;
                    cnt_next    = CNT_W'(WR_CYCLE - 1);
                    strobe_next = write_strobe(1'b0, ~wr_byteenable);
                    dq_oe_next  = 1'b1;
                    addr_load   = 1'b1;
                    addr_next   = wr_address;
                    data_load   = 1'b1;
                end
            end
            READ: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                    capture    = 1'b1;
                end else begin
                    cnt_next    = cnt - CNT_W'(1);
                    strobe_next = SRAM_STROBE_READ;
                end
            end
            WRITE: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next    = cnt - CNT_W'(1);
                    strobe_next = write_strobe(cnt == CNT_W'(1), sram_be_n);
                    dq_oe_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read-valid strobe follows the capture by one edge, aligned with the data.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= capture;
        end
    end

    assign rd_readdatavalid = rd_valid_q;

    fb_sram_io #(
        .SRAM_AW (SRAM_AW),
        .SRAM_DW (SRAM_DW)
    ) u_io (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .addr_load  (addr_load),
        .addr_next  (addr_next),
        .data_load  (data_load),
        .data_next  (wr_writedata),
        .ce_n_next  (strobe_next.ce_n),
        .oe_n_next  (strobe_next.oe_n),
        .we_n_next  (strobe_next.we_n),
        .be_n_next  (strobe_next.be_n),
        .dq_oe_next (dq_oe_next),
        .capture    (capture),
        .sram_addr  (sram_addr),
        .sram_dq    (sram_dq),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_be_n  (sram_be_n),
        .rd_data    (rd_readdata)
    );

endmodule

// File: tb/tb_fb_sram_arbiter.sv
// Bench for fb_sram_arbiter with an asynchronous SRAM model on the pins.
// Read results go through a scoreboard queue (expected data and the cycle
// in which rd_readdatavalid must appear).

module tb_fb_sram_arbiter;

    localparam int AW     = 18;
    localparam int DW     = 16;
    localparam int RD_LAT = 3;   // RD_CYCLE + 1 with the default RD_CYCLE=2

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          rd_read   = 1'b0;
    logic [AW-1:0] rd_address = '0;
    logic          rd_waitrequest;
    logic [DW-1:0] rd_readdata;
    logic          rd_readdatavalid;
    logic          wr_write  = 1'b0;
    logic [AW-1:0] wr_address = '0;
    logic [DW-1:0] wr_writedata = '0;
    logic [1:0]    wr_byteenable = 2'b00;
    logic          wr_waitrequest;
    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_dq;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic [1:0]    sram_be_n;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    bit            preloaded = 1'b0;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } sb_t;
    sb_t sb_q[$];
    sb_t mon_e;

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    be;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vecs[9];

    fb_sram_arbiter dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .rd_read          (rd_read),
        .rd_address       (rd_address),
        .rd_waitrequest   (rd_waitrequest),
        .rd_readdata      (rd_readdata),
        .rd_readdatavalid (rd_readdatavalid),
        .wr_write         (wr_write),
        .wr_address       (wr_address),
        .wr_writedata     (wr_writedata),
        .wr_byteenable    (wr_byteenable),
        .wr_waitrequest   (wr_waitrequest),
        .sram_addr        (sram_addr),
        .sram_dq          (sram_dq),
        .sram_ce_n        (sram_ce_n),
        .sram_oe_n        (sram_oe_n),
        .sram_we_n        (sram_we_n),
        .sram_be_n        (sram_be_n)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // SRAM model: drives the bus while read-enabled, writes bytes while we_n low.
    assign sram_dq = (sram_ce_n === 1'b0 && sram_oe_n === 1'b0 && sram_we_n === 1'b1)
                     ? mem[sram_addr] : {DW{1'bz}};

    always @(negedge sys_clk) begin
        if (!preloaded) begin
            mem[18'h00010] = 16'hBEEF;
            mem[18'h00200] = 16'hFFFF;
            mem[18'h00300] = 16'h0F0F;
            mem[18'h3FFFF] = 16'h1200;
            preloaded = 1'b1;
        end
        if (sram_ce_n === 1'b0 && sram_we_n === 1'b0) begin
            if (sram_be_n[0] == 1'b0) mem[sram_addr][7:0]  = sram_dq[7:0];
            if (sram_be_n[1] == 1'b0) mem[sram_addr][15:8] = sram_dq[15:8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Read-return monitor: every valid must match the head of the scoreboard.
    always @(negedge sys_clk) begin
        if (rd_readdatavalid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got data %h with no read outstanding (cycle %0d)",
                         rd_readdata, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("rd_readdata", 32'(rd_readdata), 32'(mon_e.data));
                check("rd_latency_cycle", 32'(cyc), 32'(mon_e.due));
            end
        end
    end

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                           input bit push, output int t_acc);
        @(posedge sys_clk); #1;
        rd_read    = 1'b1;
        rd_address = a;
        t_acc      = -1;
        for (int n = 0; n < 50 && t_acc < 0; n++) begin
            @(negedge sys_clk);
            if (!rd_waitrequest) begin
                t_acc = cyc;
                if (push) sb_q.push_back('{exp_d, cyc + RD_LAT});
            end
        end
        if (t_acc < 0) fail_now("rd_accept");
        @(posedge sys_clk); #1;
        rd_read = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [1:0] be, output int t_acc);
        @(posedge sys_clk); #1;
        wr_write      = 1'b1;
        wr_address    = a;
        wr_writedata  = d;
        wr_byteenable = be;
        t_acc         = -1;
        for (int n = 0; n < 50 && t_acc < 0; n++) begin
            @(negedge sys_clk);
            if (!wr_waitrequest) t_acc = cyc;
        end
        if (t_acc < 0) fail_now("wr_accept");
        @(posedge sys_clk); #1;
        wr_write = 1'b0;
    endtask

    initial begin
        int t;
        int t_rd;
        int t_wr;
        int n_acc;
        int n_rd;
        int wr_at;
        logic prev_ce;

        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int t_rd;
        int t_wr;
        int n_acc;
        int n_rd;
        int wr_at;
        logic prev_ce;

        vecs[0] = '{1'b1, 18'h00100, 16'h1234, 2'b11, 16'h1234};
        vecs[1] = '{1'b0, 18'h00100, 16'h0000, 2'b00, 16'h1234};
        vecs[2] = '{1'b1, 18'h00100, 16'hABCD, 2'b10, 16'hAB34};
        vecs[3] = '{1'b0, 18'h00100, 16'h0000, 2'b00, 16'hAB34};
        vecs[4] = '{1'b1, 18'h00200, 16'h5678, 2'b01, 16'hFF78};
        vecs[5] = '{1'b0, 18'h00200, 16'h0000, 2'b00, 16'hFF78};
        vecs[6] = '{1'b1, 18'h00300, 16'h9999, 2'b00, 16'h0F0F};
        vecs[7] = '{1'b0, 18'h00300, 16'h0000, 2'b00, 16'h0F0F};
        vecs[8] = '{1'b0, 18'h00010, 16'h0000, 2'b00, 16'hBEEF};

        // Reset with both requests high: nothing may be granted.
        sys_rst_n = 1'b0;
        rd_read   = 1'b1;
        wr_write  = 1'b1;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_rd_waitrequest", 32'(rd_waitrequest), 32'd1);
        check("rst_wr_waitrequest", 32'(wr_waitrequest), 32'd1);
        check("rst_ce_n", 32'(sram_ce_n), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_be_n", 32'(sram_be_n), 32'd3);
        check("rst_dq_z", 32'(sram_dq === 16'hzzzz), 32'd1);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_valid", 32'(rd_readdatavalid), 32'd0);
        check("rst_readdata", 32'(rd_readdata), 32'd0);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        rd_read   = 1'b0;
        wr_write  = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("idle_rd_waitrequest", 32'(rd_waitrequest), 32'd1);
        check("idle_wr_waitrequest", 32'(wr_waitrequest), 32'd1);

        // Single read: oe_n low two cycles, valid three cycles after accept.
        do_read(18'h00010, 16'hBEEF, 1'b1, t);
        @(negedge sys_clk);
        check("rd_c1_oe_n", 32'(sram_oe_n), 32'd0);
        check("rd_c1_addr", 32'(sram_addr), 32'h10);
        check("rd_c1_be_n", 32'(sram_be_n), 32'd0);
        @(negedge sys_clk);
        check("rd_c2_oe_n", 32'(sram_oe_n), 32'd0);
        check("rd_c2_valid", 32'(rd_readdatavalid), 32'd0);
        @(negedge sys_clk);
        check("rd_c3_oe_n", 32'(sram_oe_n), 32'd1);
        check("rd_c3_valid", 32'(rd_readdatavalid), 32'd1);
        @(negedge sys_clk);
        check("rd_c4_valid", 32'(rd_readdatavalid), 32'd0);

        // Single write to the top address, low byte only.
        do_write(18'h3FFFF, 16'hA5A5, 2'b01, t);
        @(negedge sys_clk);
        check("wr_c1_we_n", 32'(sram_we_n), 32'd0);
        check("wr_c1_oe_n", 32'(sram_oe_n), 32'd1);
        check("wr_c1_be_n", 32'(sram_be_n), 32'd2);
        check("wr_c1_addr", 32'(sram_addr), 32'h3FFFF);
        check("wr_c1_dq", 32'(sram_dq), 32'hA5A5);
        @(negedge sys_clk);
        check("wr_c2_we_n", 32'(sram_we_n), 32'd1);
        check("wr_c2_ce_n", 32'(sram_ce_n), 32'd0);
        check("wr_c2_addr", 32'(sram_addr), 32'h3FFFF);
        check("wr_c2_dq", 32'(sram_dq), 32'hA5A5);
        @(negedge sys_clk);
        check("wr_c3_ce_n", 32'(sram_ce_n), 32'd1);
        check("wr_c3_dq_z", 32'(sram_dq === 16'hzzzz), 32'd1);
        check("wr_c3_wr_waitrequest", 32'(wr_waitrequest), 32'd1);
        check("wr_mem_3ffff", 32'(mem[18'h3FFFF]), 32'h12A5);

        // Table of writes and reads with byte-enable patterns.
        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].be, t);
                repeat (2) @(negedge sys_clk);
                check("vec_wr_mem", 32'(mem[vecs[i].addr]), 32'(vecs[i].exp));
            end else begin
                do_read(vecs[i].addr, vecs[i].exp, 1'b1, t);
            end
        end
        repeat (4) @(negedge sys_clk);

        // Simultaneous requests: read first, write in the valid-strobe cycle.
        @(posedge sys_clk); #1;
        rd_read       = 1'b1;
        rd_address    = 18'h00010;
        wr_write      = 1'b1;
        wr_address    = 18'h00400;
        wr_writedata  = 16'h4242;
        wr_byteenable = 2'b11;
        t_rd = -1;
        t_wr = -1;
        n_acc = 0;
        prev_ce = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (rd_read && !rd_waitrequest) begin
                t_rd = cyc;
                sb_q.push_back('{16'hBEEF, cyc + RD_LAT});
            end
            if (wr_write && !wr_waitrequest) t_wr = cyc;
            if (prev_ce && !sram_ce_n) n_acc++;
            prev_ce = sram_ce_n;
            @(posedge sys_clk); #1;
            if (t_rd >= 0) rd_read = 1'b0;
            if (t_wr >= 0) wr_write = 1'b0;
        end
        check("simul_read_granted", 32'(t_rd >= 0), 32'd1);
        check("simul_write_gap", 32'(t_wr - t_rd), 32'(RD_LAT));
        check("simul_accesses", 32'(n_acc), 32'd2);
        check("simul_mem_400", 32'(mem[18'h00400]), 32'h4242);

        // Continuous reads with a pending write.
        @(posedge sys_clk); #1;
        rd_read       = 1'b1;
        rd_address    = 18'h00010;
        wr_write      = 1'b1;
        wr_address    = 18'h00500;
        wr_writedata  = 16'h7777;
        wr_byteenable = 2'b11;
        n_rd  = 0;
        wr_at = -1;
        for (int i = 0; i < 60 && wr_at < 0 && n_rd < 12; i++) begin
            @(negedge sys_clk);
            if (!rd_waitrequest && !wr_waitrequest) begin
                fail_now("starve_double_grant");
            end
            if (!rd_waitrequest) begin
                n_rd++;
                sb_q.push_back('{16'hBEEF, cyc + RD_LAT});
            end
            if (!wr_waitrequest) wr_at = n_rd;
            @(posedge sys_clk); #1;
            if (wr_at >= 0) wr_write = 1'b0;
        end
        rd_read = 1'b0;
`ifdef FB_SRAM_ARB_STARVE_EN
        check("starve_reads_before_write", 32'(wr_at), 32'd8);
`else
        check("starve_write_never_granted", 32'(wr_at), 32'hFFFFFFFF);
        check("starve_read_count", 32'(n_rd), 32'd12);
`endif
        if (wr_write) begin
            t_wr = -1;
            for (int i = 0; i < 20 && t_wr < 0; i++) begin
                @(negedge sys_clk);
                if (!wr_waitrequest) t_wr = cyc;
                @(posedge sys_clk); #1;
                if (t_wr >= 0) wr_write = 1'b0;
            end
            if (t_wr < 0) fail_now("starve_write_drain");
        end
        do_read(18'h00500, 16'h7777, 1'b1, t);
        repeat (4) @(negedge sys_clk);

        // Reset in the first READ cycle: strobes drop, no valid for it.
        do_read(18'h00010, 16'hBEEF, 1'b0, t);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("midrst_c1_oe_n", 32'(sram_oe_n), 32'd0);
        @(negedge sys_clk);
        check("midrst_ce_n", 32'(sram_ce_n), 32'd1);
        check("midrst_oe_n", 32'(sram_oe_n), 32'd1);
        check("midrst_we_n", 32'(sram_we_n), 32'd1);
        check("midrst_be_n", 32'(sram_be_n), 32'd3);
        check("midrst_dq_z", 32'(sram_dq === 16'hzzzz), 32'd1);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        repeat (6) @(negedge sys_clk);
        check("midrst_no_valid", 32'(rd_readdatavalid), 32'd0);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
